ztex_host_link_master: RTL and testbench
========================================

Name: ztex_host_link_master

Overview:
- Host-side initiator for the byte-serial miner link.
- Loads a 352-bit job (256-bit midstate, 96-bit data) into the FPGA miner as 44 bytes strobed by rd_clk toggles.
- Polls 12 result bytes (golden_nonce, nonce2, hash2) back via a wr_start pulse followed by wr_clk toggles.
- Sits in the controller/test-harness FPGA or CPLD that drives the miner's read/rd_clk/wr_start/wr_clk/write pins; all link timing is in this block's clk cycles.

Parameters:
- BYTE_CYC, 8, cycles each rd_clk/wr_clk level is held and data is held before a toggle; must cover at least 4 miner clk periods.
- START_CYC, 8, cycles wr_start is held high; must cover at least 2 miner clk periods.
- SETTLE_CYC, 16, cycles after wr_start falls before byte 0 is sampled; must cover at least 7 miner clk periods plus 2 sync cycles.
- IN_BYTES, 44, job bytes per load.
- OUT_BYTES, 12, result bytes per poll.

Ports:
- clk  in  1  block clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- job_data  in  352  [351:96] midstate, [95:0] data
- job_valid  in  1  job offered
- job_ready  out  1  high in IDLE only; job accepted on job_valid&job_ready
- poll  in  1  single-cycle result-poll request
- res_data  out  96  {hash2, nonce2, golden_nonce}, i.e. byte 0 lands in [7:0]
- res_valid  out  1  one-cycle pulse, res_data valid
- busy  out  1  high in any state other than IDLE
- read  out  8  link data to miner
- rd_clk  out  1  link write strobe; every toggle (either edge) transfers one byte
- wr_start  out  1  freeze/restart result shift in miner
- wr_clk  out  1  link read strobe; every toggle advances miner output by one byte
- write  in  8  link data from miner; asynchronous, 2-flop synchronised internally

Behaviour:
- Reset values: read=0, rd_clk=0, wr_clk=0, wr_start=0, res_data=0, res_valid=0, job_ready=0, busy=0, poll_pending=0. State goes to IDLE.
- States: IDLE, TX_DATA, TX_STROBE, RX_START, RX_SETTLE, RX_SAMPLE, RX_STROBE, DONE.
- IDLE:
  - job_ready=1.
  - On job_valid: latch job_data into a 352-bit shift register, set byte count to 0, go to TX_DATA.
  - Otherwise, if poll or poll_pending is set: go to RX_START.
- poll arriving in any state other than IDLE sets poll_pending. poll_pending clears on entry to RX_START. Multiple polls while pending collapse into one.
- Simultaneous job_valid and poll in IDLE: job wins; poll_pending is set.
- TX_DATA:
  - read = shift[7:0], held BYTE_CYC cycles.
  - Then go to TX_STROBE.
- TX_STROBE:
  - Toggle rd_clk on entry, keep read unchanged, hold BYTE_CYC cycles.
  - Then shift right by 8 and increment count.
  - count==IN_BYTES → IDLE; otherwise → TX_DATA.
- Byte order is LSB first: job_data[7:0] first, [351:344] last.
- Job load takes IN_BYTES×2×BYTE_CYC cycles (704 at defaults). rd_clk parity after a load = previous parity XOR (IN_BYTES odd).
- RX_START: wr_start=1 for START_CYC cycles.
- RX_SETTLE: wr_start=0 for SETTLE_CYC cycles.
- RX_SAMPLE:
  - Capture the synchronised write byte into the result shift register: new byte enters [95:88], shifting right, so byte 0 ends in [7:0].
  - Increment rx count.
  - count==OUT_BYTES → DONE; otherwise → RX_STROBE.
- RX_STROBE: toggle wr_clk on entry, wait BYTE_CYC+2 cycles (sync latency), then go to RX_SAMPLE. No toggle follows the last byte.
- DONE:
  - res_data updates and res_valid=1 for exactly one cycle.
  - Go to IDLE, which may immediately serve the next poll or job.
- res_data holds its last value until the next DONE. A partial poll never updates res_data.
- read is don't-care outside TX states but holds its last driven byte.
- wr_clk and rd_clk are never reset to 0 at end of transfer; only level changes count.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - A pin changing 1→0 here appears as one extra toggle to the miner. This is acceptable: the next complete 44-byte load fully overwrites the miner job, and the next wr_start re-freezes results.
- Counters: 16 bits, count down from the parameter value minus 1. Each parameter must be ≥1.

Test Plan:
- Job load: job_data={midstate=256'h00..01, data=96'hAABBCCDD_11223344_55667788}, job_valid=1 → job_ready drops the next cycle. Bytes on read = 88,77,66,55,44,33,22,11,DD,CC,BB,AA, 01, then 31×00. 44 rd_clk toggles, each ≥8 cycles apart. read is stable 8 cycles before and after every toggle. busy is high for 704 cycles.
- Poll: miner model presents bytes 0x01..0x0C → wr_start high 8 cycles, 16 settle cycles, 11 wr_clk toggles. res_valid pulses once with res_data=96'h0C0B0A09_08070605_04030201.
- Simultaneous job_valid and poll in IDLE → full job load first, then a poll starts with no idle gap longer than 1 cycle. Exactly one res_valid.
- Three poll pulses during a job load → exactly one poll is executed afterwards. poll_pending is 0 after RX_START.
- reset driven low at byte 20 of a load → all outputs go to 0 asynchronously. A following full load with a bench miner model yields the correct 352-bit job in the model.
- BYTE_CYC=1, SETTLE_CYC=1 → the protocol still completes. Load takes 88 cycles. The poll returns the correct bytes with the 2-cycle sync respected.

Source files
------------

// File: rtl/ztex_host_link_master.sv
// ztex_host_link_master: host-side initiator for the byte-serial miner link; loads
// 44-byte jobs via rd_clk toggles and polls 12 result bytes via wr_start/wr_clk.
module ztex_host_link_master #(
    parameter int BYTE_CYC   = 8,
    parameter int START_CYC  = 8,
    parameter int SETTLE_CYC = 16,
    parameter int IN_BYTES   = 44,
    parameter int OUT_BYTES  = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [351:0] job_data,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic         poll,
    output logic [95:0]  res_data,
    output logic         res_valid,
    output logic         busy,
    output logic [7:0]   read,
    output logic         rd_clk,
    output logic         wr_start,
    output logic         wr_clk,
    input  logic [7:0]   write
);
    typedef enum logic [2:0] {
        IDLE, TX_DATA, TX_STROBE, RX_START, RX_SETTLE, RX_SAMPLE, RX_STROBE, DONE
    } state_t;

    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n, idx;
    logic [351:0]  shift;
    logic [87:0]   rx;
    logic [7:0]    w1, w2;
    logic          poll_pending, entry, tick, tx_last, rx_last;

    // The current job byte always sits in shift[7:0], so read simply mirrors it.
    assign read = shift[7:0];

    always_comb begin
        state_n = state;
        tick    = cnt == 16'd0;
        tx_last = idx == 16'(IN_BYTES - 1);
        rx_last = idx == 16'(OUT_BYTES - 1);
        case (state)
            IDLE:      state_n = (job_valid && job_ready) ? TX_DATA :
                                 (poll || poll_pending) ? RX_START : IDLE;
            TX_DATA:   state_n = tick ? TX_STROBE : TX_DATA;
            TX_STROBE: state_n = !tick ? TX_STROBE : tx_last ? IDLE : TX_DATA;
            RX_START:  state_n = tick ? RX_SETTLE : RX_START;
            RX_SETTLE: state_n = tick ? RX_SAMPLE : RX_SETTLE;
            RX_SAMPLE: state_n = rx_last ? DONE : RX_STROBE;
            RX_STROBE: state_n = tick ? RX_SAMPLE : RX_STROBE;
            DONE:      state_n = IDLE;
        endcase
        entry = state_n != state;
        cnt_n = !entry ? (tick ? cnt : cnt - 16'd1) :
                (state_n == TX_DATA || state_n == TX_STROBE) ? 16'(BYTE_CYC - 1) :
                state_n == RX_START  ? 16'(START_CYC - 1) :
                state_n == RX_SETTLE ? 16'(SETTLE_CYC - 1) :
                state_n == RX_STROBE ? 16'(BYTE_CYC + 1) : 16'd0;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            rx           <= '0;
            w1           <= '0;
            w2           <= '0;
            poll_pending <= 1'b0;
            job_ready    <= 1'b0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            rd_clk       <= 1'b0;
            wr_clk       <= 1'b0;
            wr_start     <= 1'b0;
        end else begin
            cnt          <= cnt_n;
            w1           <= write;
            w2           <= w1;
            job_ready    <= state_n == IDLE;
            busy         <= state_n != IDLE;
            res_valid    <= state_n == DONE;
            poll_pending <= (entry && state_n == RX_START) ? 1'b0 : poll_pending | poll;
            if (entry && state_n == TX_DATA) begin
                shift <= state == IDLE ? job_data : shift >> 8;
                idx   <= state == IDLE ? 16'd0 : idx + 16'd1;
            end
            if (entry && state_n == TX_STROBE) rd_clk <= ~rd_clk;
            if (entry && state_n == RX_START) begin
                wr_start <= 1'b1;
                idx      <= 16'd0;
            end
            if (entry && state_n == RX_SETTLE) wr_start <= 1'b0;
            // Sampled bytes enter at the top so byte 0 ends up in the low bits.
            if (state == RX_SAMPLE) begin
                rx  <= {w2, rx[87:8]};
                idx <= idx + 16'd1;
            end
            if (state_n == DONE) res_data <= {w2, rx};
            if (entry && state_n == RX_STROBE) wr_clk <= ~wr_clk;
        end
    end
endmodule

// File: tb/tb_ztex_host_link_master.sv
// tb_ztex_host_link_master: randomized bench with a behavioural miner model for a
// default-timed and a fast (BYTE_CYC=1, SETTLE_CYC=1) instance of the link master.
module tb_ztex_host_link_master;
    localparam int IN_BYTES  = 44;
    localparam int OUT_BYTES = 12;
    localparam int DEPTH     = 2048;

    logic         clk = 1'b0;
    logic         reset [2];
    logic [351:0] job_data [2];
    logic         job_valid [2], job_ready [2], poll [2], res_valid [2], busy [2];
    logic         rd_clk [2], wr_start [2], wr_clk [2];
    logic [95:0]  res_data [2];
    logic [7:0]   read [2], write [2];

    int           bc [2] = '{8, 1};
    int           checks = 0, errors = 0, cyc = 0;
    logic [351:0] mjob [2];
    logic [7:0]   mres [2][OUT_BYTES];
    logic [95:0]  exp_res [2];
    int           rd_n [2] = '{0, 0}, rc_n [2] = '{0, 0}, wr_n [2] = '{0, 0};
    int           ws_n [2] = '{0, 0}, rv_n [2] = '{0, 0}, ridx [2] = '{0, 0};
    int           rv0 [2], wr0 [2], ws0 [2];
    int           rd_t [2][DEPTH], rc_t [2][DEPTH];

    ztex_host_link_master u_def (
        .clk(clk), .reset(reset[0]), .job_data(job_data[0]), .job_valid(job_valid[0]),
        .job_ready(job_ready[0]), .poll(poll[0]), .res_data(res_data[0]), .res_valid(res_valid[0]),
        .busy(busy[0]), .read(read[0]), .rd_clk(rd_clk[0]), .wr_start(wr_start[0]),
        .wr_clk(wr_clk[0]), .write(write[0])
    );

    ztex_host_link_master #(.BYTE_CYC(1), .SETTLE_CYC(1)) u_fast (
        .clk(clk), .reset(reset[1]), .job_data(job_data[1]), .job_valid(job_valid[1]),
        .job_ready(job_ready[1]), .poll(poll[1]), .res_data(res_data[1]), .res_valid(res_valid[1]),
        .busy(busy[1]), .read(read[1]), .rd_clk(rd_clk[1]), .wr_start(wr_start[1]),
        .wr_clk(wr_clk[1]), .write(write[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Miner model: every rd_clk level change shifts in one job byte; wr_start
    // restarts the result stream and each wr_clk change advances it after a delay.
    for (genvar g = 0; g < 2; g++) begin : g_miner
        always @(rd_clk[g]) begin
            mjob[g] = {read[g], mjob[g][351:8]};
            if (rd_n[g] < DEPTH) rd_t[g][rd_n[g]] = cyc;
            rd_n[g]++;
        end
        always @(read[g]) begin
            if (rc_n[g] < DEPTH) rc_t[g][rc_n[g]] = cyc;
            rc_n[g]++;
        end
        always @(posedge wr_start[g] or wr_clk[g]) begin
            if (wr_start[g]) ridx[g] = 0;
            else begin
                wr_n[g]++;
                ridx[g]++;
                #2;
            end
            if (ridx[g] < OUT_BYTES) write[g] = mres[g][ridx[g]];
        end
        always @(posedge clk) begin
            if (wr_start[g]) ws_n[g]++;
            if (res_valid[g]) rv_n[g]++;
        end
    end

    task automatic check(input string tag, input logic [351:0] got, input logic [351:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [351:0] rand_job();
        logic [351:0] d;
        for (int k = 0; k < 11; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    task automatic wait_ready(input int i);
        int n = 0;
        while (!(job_ready[i] && !busy[i]) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("ready_timeout", n < 3000, 1);
    endtask

    task automatic load(input int i, input logic [351:0] d, input bit with_poll, input bit extra);
        int n, t0, c0;
        bit ok;
        wait_ready(i);
        t0 = rd_n[i];
        c0 = rc_n[i];
        job_data[i]  = d;
        job_valid[i] = 1'b1;
        poll[i]      = with_poll;
        @(negedge clk);
        job_valid[i] = 1'b0;
        poll[i]      = 1'b0;
        check("job_ready_drop", job_ready[i], 0);
        n = 0;
        while (busy[i] && n < 5000) begin
            n++;
            poll[i] = extra && (n == 50 || n == 51 || n == 200 || n == 400);
            @(negedge clk);
        end
        poll[i] = 1'b0;
        check("load_cycles", n, 2 * IN_BYTES * bc[i]);
        check("rd_toggles", rd_n[i] - t0, IN_BYTES);
        check("job_in_miner", mjob[i], d);
        ok = 1'b1;
        for (int k = t0; k < rd_n[i] && k < DEPTH; k++) begin
            if (k > t0 && rd_t[i][k] - rd_t[i][k-1] < bc[i]) ok = 1'b0;
            for (int c = c0; c < rc_n[i] && c < DEPTH; c++)
                if (rc_t[i][c] - rd_t[i][k] < bc[i] && rd_t[i][k] - rc_t[i][c] < bc[i]) ok = 1'b0;
        end
        check("read_setup_hold", ok, 1);
    endtask

    task automatic set_res(input int i, input bit fixed);
        for (int k = 0; k < OUT_BYTES; k++) begin
            mres[i][k] = fixed ? 8'(k + 1) : 8'($urandom);
            exp_res[i][8*k +: 8] = mres[i][k];
        end
        rv0[i] = rv_n[i];
        wr0[i] = wr_n[i];
        ws0[i] = ws_n[i];
    endtask

    task automatic await_res(input int i);
        int n = 0;
        while (!res_valid[i] && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("res_timeout", n < 3000, 1);
        check("res_data", res_data[i], exp_res[i]);
        repeat (60) @(negedge clk);
        check("res_pulses", rv_n[i] - rv0[i], 1);
        check("wr_toggles", wr_n[i] - wr0[i], OUT_BYTES - 1);
        check("wr_start_cycles", ws_n[i] - ws0[i], 8);
        check("idle_after_poll", busy[i], 0);
        check("res_hold", res_data[i], exp_res[i]);
    endtask

    task automatic do_poll(input int i, input bit fixed);
        wait_ready(i);
        set_res(i, fixed);
        poll[i] = 1'b1;
        @(negedge clk);
        poll[i] = 1'b0;
        await_res(i);
    endtask

    initial begin
        int n, t0;
        for (int i = 0; i < 2; i++) begin
            reset[i]     = 1'b1;
            job_valid[i] = 1'b0;
            poll[i]      = 1'b0;
            job_data[i]  = '0;
            write[i]     = '0;
        end
        #3 reset = '{1'b0, 1'b0};
        #1;
        for (int i = 0; i < 2; i++)
            check("reset_values", {read[i], rd_clk[i], wr_clk[i], wr_start[i], res_valid[i],
                                   job_ready[i], busy[i], res_data[i]}, 0);
        repeat (3) @(negedge clk);
        reset = '{1'b1, 1'b1};
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) check("ready_after_reset", {job_ready[i], busy[i]}, 2'b10);

        load(0, {256'h1, 96'hAABBCCDD_11223344_55667788}, 1'b0, 1'b0);
        do_poll(0, 1'b1);

        set_res(0, 1'b0);
        load(0, rand_job(), 1'b1, 1'b0);
        @(negedge clk);
        check("poll_follows_load", busy[0], 1);
        await_res(0);

        set_res(0, 1'b0);
        load(0, rand_job(), 1'b0, 1'b1);
        await_res(0);

        wait_ready(0);
        t0 = rd_n[0];
        job_data[0]  = rand_job();
        job_valid[0] = 1'b1;
        @(negedge clk);
        job_valid[0] = 1'b0;
        n = 0;
        while (rd_n[0] - t0 < 20 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("reach_byte20", n < 2000, 1);
        #2 reset[0] = 1'b0;
        #1 check("reset_mid_load", {read[0], rd_clk[0], wr_clk[0], wr_start[0], res_valid[0],
                                    job_ready[0], busy[0], res_data[0]}, 0);
        @(negedge clk);
        reset[0] = 1'b1;
        load(0, rand_job(), 1'b0, 1'b0);
        do_poll(0, 1'b0);

        for (int r = 0; r < 2; r++) begin
            load(0, rand_job(), 1'b0, 1'b0);
            do_poll(0, 1'b0);
        end

        load(1, {256'h1, 96'hAABBCCDD_11223344_55667788}, 1'b0, 1'b0);
        do_poll(1, 1'b1);
        for (int r = 0; r < 4; r++) begin
            load(1, rand_job(), 1'b0, 1'b0);
            do_poll(1, 1'b0);
        end
        set_res(1, 1'b0);
        load(1, rand_job(), 1'b1, 1'b0);
        @(negedge clk);
        check("fast_poll_follows_load", busy[1], 1);
        await_res(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
